// File: rtl/act_buffer_nbank_pkg.sv
// Shared definitions for the N-bank activation buffer.
// Contents:
//   LANE_W  - bit width of one activation lane (one byte)
//   bank_w  - width of a bank index for a given bank count
//   cnt_w   - width of a counter that must hold 0..num_banks inclusive
package act_buffer_nbank_pkg;

  localparam int LANE_W = 8;

  // A bank index needs at least one bit, even for the degenerate single-bank case.
  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // The counter must represent the "all banks full" value, hence num_banks+1 states.
  function automatic int cnt_w(input int num_banks);
    return $clog2(num_banks + 1);
  endfunction

endpackage

// File: rtl/act_buffer_nbank_bank_ram.sv
// One activation bank: simple dual-port memory shaped for BRAM inference.
// Ports:
//   buf_gated_clk  in   clock
//   wr_en          in   write strobe
//   wr_addr        in   word address for the write
//   wr_data        in   TM*8-bit write vector
//   wr_lane_en     in   per-lane (byte) write enable
//   rd_en          in   read strobe; rd_data updates one cycle later
//   rd_addr        in   word address for the read
//   rd_data        out  registered read word, holds between reads
// No reset: contents and the read register are undefined until written.
module act_bank_ram
  import act_buffer_nbank_pkg::*;
#(
  parameter int TM         = 14,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                     buf_gated_clk,
  input  logic                     wr_en,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [TM*LANE_W-1:0]     wr_data,
  input  logic [TM-1:0]            wr_lane_en,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [TM*LANE_W-1:0]     rd_data
);

  logic [TM*LANE_W-1:0] mem [2**ADDR_WIDTH];

  // Byte-masked write and registered read share one clocked process so the
  // tools see a standard byte-enable RAM template.
  always_ff @(posedge buf_gated_clk) begin
    if (wr_en) begin
      for (int i = 0; i < TM; i++) begin
        if (wr_lane_en[i]) begin
          mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/act_buffer_nbank.sv
// N-bank activation buffer between the DMA write path and the systolic array
// A-input. Banks are filled round-robin and committed by the DMA, then read
// and released by the array, forming a FIFO of whole banks.
// Ports:
//   buf_gated_clk  in   clock (gated upstream)
//   rst_n          in   async active-low reset
//   flush          in   sync clear of pointers, count and read pipe
//   wr_en/wr_addr/wr_data/wr_lane_en  in   masked write into the write bank
//   wr_commit      in   hand the write bank to the reader
//   wr_bank_avail  out  write bank is free
//   wr_bank_id     out  write bank index
//   rd_en/rd_addr  in   read from the read bank
//   rd_release     in   hand the read bank back to the writer
//   rd_bank_avail  out  a committed bank is readable
//   rd_bank_id     out  read bank index
//   a_vec          out  read data, RD_LATENCY cycles after rd_en
//   a_vec_valid    out  a_vec carries data from an accepted read
//   full_cnt       out  committed, unreleased banks
//   err_wr/err_rd  out  sticky protocol-error flags (cleared by rst_n only)
module act_buffer_nbank
  import act_buffer_nbank_pkg::*;
#(
  parameter int TM           = 14,
  parameter int ADDR_WIDTH   = 7,
  parameter int NUM_BANKS    = 4,
  parameter int RD_LATENCY   = 1,
  parameter int ZERO_ON_IDLE = 1,
  localparam int BANK_W      = bank_w(NUM_BANKS),
  localparam int CNT_W       = cnt_w(NUM_BANKS),
  localparam int VEC_W       = TM * LANE_W
) (
  input  logic                    buf_gated_clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [VEC_W-1:0]        wr_data,
  input  logic [TM-1:0]           wr_lane_en,
  input  logic                    wr_commit,
  output logic                    wr_bank_avail,
  output logic [BANK_W-1:0]       wr_bank_id,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_release,
  output logic                    rd_bank_avail,
  output logic [BANK_W-1:0]       rd_bank_id,
  output logic [VEC_W-1:0]        a_vec,
  output logic                    a_vec_valid,
  output logic [CNT_W-1:0]        full_cnt,
  output logic                    err_wr,
  output logic                    err_rd
);

  logic [BANK_W-1:0] wp;
  logic [BANK_W-1:0] rp;
  logic [CNT_W-1:0]  cnt;

  logic do_write;
  logic do_commit;
  logic do_read;
  logic do_release;

  logic [VEC_W-1:0]  bank_q [NUM_BANKS];
  logic              v1;
  logic [BANK_W-1:0] sel1;
  logic [VEC_W-1:0]  rd_word;

  assign wr_bank_avail = (cnt < CNT_W'(NUM_BANKS));
  assign rd_bank_avail = (cnt != '0);
  assign wr_bank_id    = wp;
  assign rd_bank_id    = rp;
  assign full_cnt      = cnt;

  // Memory writes are not gated by flush: a write in a flush cycle still lands.
  assign do_write   = wr_en      && wr_bank_avail;
  assign do_commit  = wr_commit  && wr_bank_avail;
  assign do_read    = rd_en      && rd_bank_avail;
  assign do_release = rd_release && rd_bank_avail;

  // Bank pointers and occupancy. NUM_BANKS is a power of two, so pointer
  // wrap is the natural overflow of BANK_W bits.
  always_ff @(posedge buf_gated_clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_commit)  wp <= wp + 1'b1;
      if (do_release) rp <= rp + 1'b1;
      cnt <= cnt + CNT_W'(do_commit) - CNT_W'(do_release);
    end
  end

  // Sticky protocol errors survive flush so software can inspect them later.
  always_ff @(posedge buf_gated_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_wr <= 1'b0;
      err_rd <= 1'b0;
    end else begin
      if ((wr_en || wr_commit) && !wr_bank_avail) err_wr <= 1'b1;
      if ((rd_en || rd_release) && !rd_bank_avail) err_rd <= 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    act_bank_ram #(
      .TM         (TM),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .buf_gated_clk (buf_gated_clk),
      .wr_en         (do_write && (wp == BANK_W'(b))),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_lane_en    (wr_lane_en),
      .rd_en         (do_read && (rp == BANK_W'(b))),
      .rd_addr       (rd_addr),
      .rd_data       (bank_q[b])
    );
  end

  // First read stage tracks which bank the RAM output belongs to, since rp
  // may advance in the same cycle as the read (read + release).
  always_ff @(posedge buf_gated_clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      sel1 <= '0;
    end else if (flush) begin
      v1   <= 1'b0;
    end else begin
      v1 <= do_read;
      if (do_read) sel1 <= rp;
    end
  end

  assign rd_word = bank_q[sel1];

  if (RD_LATENCY == 2) begin : g_lat2
    logic             v2;
    logic [VEC_W-1:0] d2;

    // Extra output register for timing; idle cycles either zero or hold it.
    always_ff @(posedge buf_gated_clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (flush) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) begin
          d2 <= rd_word;
        end else if (ZERO_ON_IDLE != 0) begin
          d2 <= '0;
        end
      end
    end

    assign a_vec       = d2;
    assign a_vec_valid = v2;
  end else begin : g_lat1
    assign a_vec_valid = v1;

    if (ZERO_ON_IDLE != 0) begin : g_zero
      assign a_vec = v1 ? rd_word : '0;
    end else begin : g_hold
      logic [VEC_W-1:0] held;

      // The RAM read register is unreset, so a separate resettable copy
      // provides the held value between reads.
      always_ff @(posedge buf_gated_clk or negedge rst_n) begin
        if (!rst_n) begin
          held <= '0;
        end else if (flush) begin
          held <= '0;
        end else if (v1) begin
          held <= rd_word;
        end
      end

      assign a_vec = v1 ? rd_word : held;
    end
  end

endmodule

// File: tb/tb_act_buffer_nbank.sv
// Self-checking bench for act_buffer_nbank. A RD_LATENCY=1 and a
// RD_LATENCY=2 instance share every input, so their bank state is identical
// and only the output timing differs.
module tb_act_buffer_nbank;

  localparam int TM = 14;
  localparam int AW = 7;
  localparam int VW = TM * 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_data;
  logic [TM-1:0] wr_lane_en;
  logic          wr_commit;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_release;

  logic          wr_bank_avail, rd_bank_avail, a_vec_valid, err_wr, err_rd;
  logic [1:0]    wr_bank_id, rd_bank_id;
  logic [VW-1:0] a_vec;
  logic [2:0]    full_cnt;

  logic          wr_bank_avail2, rd_bank_avail2, a_vec_valid2, err_wr2, err_rd2;
  logic [1:0]    wr_bank_id2, rd_bank_id2;
  logic [VW-1:0] a_vec2;
  logic [2:0]    full_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  act_buffer_nbank #(.TM(TM), .ADDR_WIDTH(AW), .NUM_BANKS(4), .RD_LATENCY(1), .ZERO_ON_IDLE(1)) dut (
    .buf_gated_clk (clk),        .rst_n (rst_n),            .flush (flush),
    .wr_en (wr_en),              .wr_addr (wr_addr),        .wr_data (wr_data),
    .wr_lane_en (wr_lane_en),    .wr_commit (wr_commit),    .wr_bank_avail (wr_bank_avail),
    .wr_bank_id (wr_bank_id),    .rd_en (rd_en),            .rd_addr (rd_addr),
    .rd_release (rd_release),    .rd_bank_avail (rd_bank_avail), .rd_bank_id (rd_bank_id),
    .a_vec (a_vec),              .a_vec_valid (a_vec_valid), .full_cnt (full_cnt),
    .err_wr (err_wr),            .err_rd (err_rd)
  );

  act_buffer_nbank #(.TM(TM), .ADDR_WIDTH(AW), .NUM_BANKS(4), .RD_LATENCY(2), .ZERO_ON_IDLE(1)) dut2 (
    .buf_gated_clk (clk),        .rst_n (rst_n),            .flush (flush),
    .wr_en (wr_en),              .wr_addr (wr_addr),        .wr_data (wr_data),
    .wr_lane_en (wr_lane_en),    .wr_commit (wr_commit),    .wr_bank_avail (wr_bank_avail2),
    .wr_bank_id (wr_bank_id2),   .rd_en (rd_en),            .rd_addr (rd_addr),
    .rd_release (rd_release),    .rd_bank_avail (rd_bank_avail2), .rd_bank_id (rd_bank_id2),
    .a_vec (a_vec2),             .a_vec_valid (a_vec_valid2), .full_cnt (full_cnt2),
    .err_wr (err_wr2),           .err_rd (err_rd2)
  );

  typedef struct {
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_byte;
    logic       commit;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic       rel;
    logic       flush;
    int         exp_cnt;
    int         exp_wp;
    int         exp_rp;
    logic       exp_valid;
    logic [7:0] exp_byte;
    logic       exp_err_wr;
    logic       exp_err_rd;
  } vec_t;

  vec_t vt [13];

  // Same byte replicated in every lane.
  function automatic logic [VW-1:0] rep(input logic [7:0] b);
    logic [VW-1:0] r;
    for (int i = 0; i < TM; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    flush = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_lane_en = '1;
    wr_commit = 0; rd_en = 0; rd_addr = '0; rd_release = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = rep(v.wr_byte); wr_lane_en = '1;
    wr_commit = v.commit; rd_en = v.rd_en; rd_addr = v.rd_addr;
    rd_release = v.rel; flush = v.flush;
    step();
  endtask

  initial begin
    logic [VW-1:0] exp_vec;

    // wr_en wa  wbyte  cm rd ra rel fl | cnt wp rp vld ebyte ewr erd
    vt[0]  = '{1, 0, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0};
    vt[1]  = '{1, 1, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0};
    vt[2]  = '{1, 2, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0};
    vt[3]  = '{1, 3, 8'h04, 1, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0};
    vt[4]  = '{0, 0, 8'h00, 0, 1, 2, 0, 0, 1, 1, 0, 1, 8'h03, 0, 0};
    vt[5]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0};
    vt[6]  = '{1, 0, 8'h11, 1, 0, 0, 0, 0, 2, 2, 0, 0, 8'h00, 0, 0};
    vt[7]  = '{0, 0, 8'h00, 1, 1, 3, 1, 0, 2, 3, 1, 1, 8'h04, 0, 0};
    vt[8]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 2, 3, 1, 1, 8'h11, 0, 0};
    vt[9]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 3, 2, 0, 8'h00, 0, 0};
    vt[10] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 3, 3, 0, 8'h00, 0, 0};
    vt[11] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 3, 3, 0, 8'h00, 0, 1};
    vt[12] = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 1};

    setIdle();
    rst_n = 0;
    step();
    step();
    checkOutput("reset full_cnt", full_cnt, 0);
    checkOutput("reset wr_avail", wr_bank_avail, 1);
    checkOutput("reset rd_avail", rd_bank_avail, 0);
    checkOutput("reset valid", a_vec_valid, 0);
    checkOutput("reset a_vec", a_vec, 0);
    checkOutput("reset errs", {err_wr, err_rd}, 0);
    rst_n = 1;
    step();

    // Fill/read bank0, write+commit, commit+release, empty read error, flush.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vt[i]);
      checkOutput($sformatf("row%0d full_cnt", i), full_cnt, vt[i].exp_cnt);
      checkOutput($sformatf("row%0d wr_id", i), wr_bank_id, vt[i].exp_wp);
      checkOutput($sformatf("row%0d rd_id", i), rd_bank_id, vt[i].exp_rp);
      checkOutput($sformatf("row%0d wr_avail", i), wr_bank_avail, vt[i].exp_cnt < 4);
      checkOutput($sformatf("row%0d rd_avail", i), rd_bank_avail, vt[i].exp_cnt != 0);
      checkOutput($sformatf("row%0d valid", i), a_vec_valid, vt[i].exp_valid);
      checkOutput($sformatf("row%0d a_vec", i), a_vec, rep(vt[i].exp_byte));
      checkOutput($sformatf("row%0d err_wr", i), err_wr, vt[i].exp_err_wr);
      checkOutput($sformatf("row%0d err_rd", i), err_rd, vt[i].exp_err_rd);
    end
    setIdle();

    // Async reset clears the sticky read error without a clock edge.
    rst_n = 0;
    #1;
    checkOutput("rst clears err_rd", err_rd, 0);
    step();
    rst_n = 1;
    step();

    // All four banks committed, overflow write dropped.
    for (int b = 0; b < 4; b++) begin
      wr_en = 1; wr_addr = 5; wr_data = rep(8'hA0 + 8'(b)); wr_commit = 1;
      step();
    end
    setIdle();
    checkOutput("full wr_avail", wr_bank_avail, 0);
    checkOutput("full full_cnt", full_cnt, 4);
    checkOutput("full wr_id", wr_bank_id, 0);
    checkOutput("full rd_id", rd_bank_id, 0);
    wr_en = 1; wr_addr = 5; wr_data = rep(8'h55);
    step();
    setIdle();
    checkOutput("overflow err_wr", err_wr, 1);
    checkOutput("overflow full_cnt", full_cnt, 4);
    for (int b = 0; b < 4; b++) begin
      rd_en = 1; rd_addr = 5; rd_release = 1;
      step();
      checkOutput($sformatf("bank%0d intact valid", b), a_vec_valid, 1);
      checkOutput($sformatf("bank%0d intact data", b), a_vec, rep(8'hA0 + 8'(b)));
    end
    setIdle();
    step();
    checkOutput("drained full_cnt", full_cnt, 0);

    // Lane mask: only lane0 overwritten.
    wr_en = 1; wr_addr = 7; wr_data = rep(8'hAA);
    step();
    wr_data = rep(8'hFF); wr_lane_en = 14'h0001;
    step();
    setIdle();
    wr_commit = 1;
    step();
    setIdle();
    rd_en = 1; rd_addr = 7; rd_release = 1;
    step();
    setIdle();
    exp_vec = rep(8'hAA);
    exp_vec[7:0] = 8'hFF;
    checkOutput("lane mask data", a_vec, exp_vec);
    checkOutput("lane mask valid", a_vec_valid, 1);

    // Wrap through nine banks; check both latencies.
    flush = 1;
    step();
    setIdle();
    checkOutput("flush keeps err_wr", err_wr, 1);
    checkOutput("flush wr_id", wr_bank_id, 0);
    for (int k = 0; k < 9; k++) begin
      wr_en = 1; wr_addr = 9; wr_data = rep(8'h30 + 8'(k)); wr_commit = 1;
      step();
      setIdle();
      rd_en = 1; rd_addr = 9; rd_release = 1;
      step();
      setIdle();
      checkOutput($sformatf("wrap%0d lat1 data", k), a_vec_valid ? a_vec : '0, rep(8'h30 + 8'(k)));
      checkOutput($sformatf("wrap%0d lat2 early", k), a_vec_valid2, 0);
      step();
      checkOutput($sformatf("wrap%0d lat1 idle", k), {a_vec_valid, a_vec}, 0);
      checkOutput($sformatf("wrap%0d lat2 data", k), {a_vec_valid2, a_vec2}, {1'b1, rep(8'h30 + 8'(k))});
    end
    checkOutput("wrap wp", wr_bank_id, 1);
    checkOutput("wrap rp", rd_bank_id, 1);
    checkOutput("wrap full_cnt", full_cnt, 0);
    checkOutput("wrap lat2 ids", {wr_bank_id2, rd_bank_id2, full_cnt2}, {2'd1, 2'd1, 3'd0});

    // Async reset mid-read drops valids immediately and none reappear.
    wr_en = 1; wr_addr = 1; wr_data = rep(8'h77); wr_commit = 1;
    step();
    setIdle();
    rd_en = 1; rd_addr = 1;
    step();
    setIdle();
    checkOutput("pre-reset valid", a_vec_valid, 1);
    rst_n = 0;
    #1;
    checkOutput("async drop valids", {a_vec_valid, a_vec_valid2}, 0);
    step();
    rst_n = 1;
    step();
    checkOutput("post-reset valids", {a_vec_valid, a_vec_valid2}, 0);
    checkOutput("post-reset err_wr", {err_wr, err_wr2}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
